// File: rtl/audio_pkt_packer.sv
// Ping-pong sample buffer that frames each full buffer as a byte packet:
// sync, sequence number, 16-bit sample count, then samples big-endian.
module audio_pkt_packer #(
    parameter int         DATA_WIDTH  = 16,
    parameter int         PKT_SAMPLES = 256,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_vld,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [7:0]            seq_num
);

    localparam int            AW       = $clog2(PKT_SAMPLES);
    localparam logic [AW-1:0] LAST_IDX = AW'(PKT_SAMPLES - 1);
    localparam logic [15:0]   PKT_LEN  = 16'(PKT_SAMPLES);

    typedef enum logic [2:0] {IDLE, HDR, FETCH, DHI, DLO} state_t;

    state_t                state;
    logic [1:0]            full;
    logic [1:0]            full_set;
    logic [1:0]            full_clr;
    logic                  wr_buf;
    logic                  rd_buf;
    logic [AW-1:0]         wr_cnt;
    logic [AW-1:0]         rd_idx;
    logic [AW-1:0]         rd_addr_idx;
    logic [1:0]            hdr_idx;
    logic [1:0]            hdr_sel;
    logic [7:0]            hdr_nxt;
    logic [DATA_WIDTH-1:0] mem [0:2*PKT_SAMPLES-1];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_en;
    logic                  drop;
    logic                  hs;
    logic                  pkt_done;

    assign wr_en    = sample_vld && !full[wr_buf];
    assign drop     = sample_vld && full[wr_buf];
    assign hs       = tx_valid && tx_ready;
    assign pkt_done = (state == DLO) && hs && (rd_idx == LAST_IDX);

    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_en && (wr_cnt == LAST_IDX))
            full_set[wr_buf] = 1'b1;
        if (pkt_done)
            full_clr[rd_buf] = 1'b1;
    end

    // Address the RAM with the index the FSM is about to move to, so the
    // registered read data is already valid during the FETCH cycle.
    always_comb begin
        rd_addr_idx = rd_idx;
        if ((state == DLO) && hs && (rd_idx != LAST_IDX))
            rd_addr_idx = rd_idx + 1'b1;
    end

    always_comb begin
        hdr_sel = hdr_idx + 2'd1;
        case (hdr_sel)
            2'd1:    hdr_nxt = seq_num;
            2'd2:    hdr_nxt = PKT_LEN[15:8];
            2'd3:    hdr_nxt = PKT_LEN[7:0];
            default: hdr_nxt = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_buf, wr_cnt}] <= sample_in;
        rd_q <= mem[{rd_buf, rd_addr_idx}];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full   <= '0;
            wr_buf <= 1'b0;
            wr_cnt <= '0;
            ovf    <= 1'b0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (wr_en) begin
                if (wr_cnt == LAST_IDX) begin
                    wr_cnt <= '0;
                    wr_buf <= ~wr_buf;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hdr_idx  <= '0;
            rd_idx   <= '0;
            rd_buf   <= 1'b0;
            seq_num  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_buf]) begin
                        state    <= HDR;
                        hdr_idx  <= '0;
                        rd_idx   <= '0;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                    end
                end
                HDR: begin
                    if (hs) begin
                        if (hdr_idx == 2'd3) begin
                            state    <= FETCH;
                            tx_valid <= 1'b0;
                        end else begin
                            hdr_idx <= hdr_sel;
                            tx_data <= hdr_nxt;
                        end
                    end
                end
                FETCH: begin
                    state    <= DHI;
                    tx_data  <= rd_q[DATA_WIDTH-1 -: 8];
                    tx_valid <= 1'b1;
                end
                DHI: begin
                    if (hs) begin
                        state   <= DLO;
                        tx_data <= rd_q[7:0];
                        tx_last <= (rd_idx == LAST_IDX);
                    end
                end
                DLO: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        if (rd_idx == LAST_IDX) begin
                            state   <= IDLE;
                            rd_buf  <= ~rd_buf;
                            seq_num <= seq_num + 8'd1;
                        end else begin
                            state  <= FETCH;
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
